// File: rtl/pipe_mem_arb.sv
// pipe_mem_arb: shares one single-port memory between the IF fetch port and the
// MEM load/store port. Each access is a registered req/ready handshake guarded by
// a watchdog. stall feeds the control unit's PC/IR write-enable.
// Optional macro PIPE_MEM_ARB_RR_EN: round-robin arbitration on a simultaneous
// request (default build: fixed data-over-fetch priority, no pointer).
module pipe_mem_arb #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          bus_err,
    output logic          stall
);
    typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [7:0] wdog;
    logic       i_elig, d_elig, grant_i, grant_d;
    logic       busy, tmo_hit, fin_ok, fin_to, fin;
    logic       ack_i_nxt, ack_d_nxt, ld_i, ld_d;

    // A requester in its ack cycle is not eligible, which blocks an immediate re-grant.
    assign i_elig  = i_req & ~i_ack;
    assign d_elig  = d_req & ~d_ack;
    assign stall   = i_elig | d_elig;
    assign tmo_hit = (wdog == 8'(TMO - 1));

`ifdef PIPE_MEM_ARB_RR_EN
    logic rr_last_d;

    // On a tie, the requester that was not granted last time wins.
    always_comb begin
        grant_d = d_elig & (~i_elig | ~rr_last_d);
        grant_i = i_elig & ~grant_d;
    end

    // Track the last granted requester (1 = data).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)   rr_last_d <= 1'b1;
        else if (ld_d) rr_last_d <= 1'b1;
        else if (ld_i) rr_last_d <= 1'b0;
    end
`else
    // Fixed priority: the MEM-stage access belongs to the older instruction.
    always_comb begin
        grant_d = d_elig;
        grant_i = i_elig & ~d_elig;
    end
`endif

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: arbitrate only in IDLE, leave BUSY on ready or watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = DBUSY;
                else if (grant_i) state_d = IBUSY;
            end
            IBUSY, DBUSY: if (fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: completion/timeout strobes and req-qualified acks.
    always_comb begin
        busy      = (state_q != IDLE);
        fin_ok    = busy & m_ready;
        fin_to    = busy & ~m_ready & tmo_hit;
        fin       = fin_ok | fin_to;
        ld_d      = (state_q == IDLE) & grant_d;
        ld_i      = (state_q == IDLE) & grant_i;
        ack_i_nxt = (state_q == IBUSY) & fin & i_req;
        ack_d_nxt = (state_q == DBUSY) & fin & d_req;
    end

    // Memory-side request registers, response capture, acks and watchdog.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            bus_err <= 1'b0;
            wdog    <= '0;
        end else begin
            i_ack   <= ack_i_nxt;
            d_ack   <= ack_d_nxt;
            bus_err <= fin_to & (ack_i_nxt | ack_d_nxt);
            if (ld_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (ld_i) begin
                m_req  <= 1'b1;
                m_we   <= 1'b0;
                m_addr <= i_addr;
            end else if (fin) begin
                m_req <= 1'b0;
                m_we  <= 1'b0;
            end
            // Timed-out accesses return zero data.
            if (fin && state_q == IBUSY) i_rdata <= fin_ok ? m_rdata : '0;
            if (fin && state_q == DBUSY) d_rdata <= fin_ok ? m_rdata : '0;
            if (!busy || fin) wdog <= '0;
            else              wdog <= wdog + 8'd1;
        end
    end
endmodule

// File: doc/pipe_mem_arb.md
# pipe_mem_arb

Single-port memory arbiter and sequencer for the pipelined CPU. It shares one unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw). It runs each access as a request/ready handshake with a watchdog. It also produces the pipeline stall that the control unit ORs into its PC/IR write-enable.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TMO, 255, watchdog limit in cycles waiting for m_ready (1..255, 8-bit counter)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  DW  fetched word; valid while i_ack is high
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1 = store (sw), 0 = load (lw)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  load data; valid while d_ack is high
- m_req  out  1  memory request; held until m_ready or timeout
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data; sampled when m_ready is high
- m_ready  in  1  memory completion, single-cycle
- bus_err  out  1  one-cycle pulse together with the ack of a timed-out access
- stall  out  1  combinational: (i_req & ~i_ack) | (d_req & ~d_ack)

## Operation
- FSM states: IDLE, IBUSY, DBUSY. Reset state is IDLE.
- Reset values: m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, bus_err=0, watchdog=0, rr pointer=data.
- **IDLE:**
  - An eligible request is one whose req is high and whose ack is low in the same cycle. This blocks re-grant during the ack cycle.
  - Default arbitration is fixed priority, data over fetch, because the MEM-stage instruction is older.
  - On a grant, the registered m_req, m_we, m_addr and m_wdata are loaded and the FSM moves to xBUSY. For a fetch grant, m_we=0 and m_wdata is held at its previous value.
- **xBUSY:**
  - m_req and the address/data outputs are held constant. The watchdog increments each cycle.
  - m_ready=1 causes the following at the next edge:
    - m_req is cleared and m_we is cleared.
    - m_rdata is captured into the granted requester's rdata register.
    - The granted requester's ack pulses for one cycle.
    - The watchdog is cleared and the FSM returns to IDLE.
  - For a store, d_rdata is still captured; its value is don't-care.
  - If the watchdog reaches TMO with m_ready low:
    - m_req is dropped and the FSM returns to IDLE.
    - The ack pulses with rdata=0, and bus_err pulses in the same cycle.
- **Requester drops req mid-access** (protocol violation, e.g. flush): the memory transaction still completes or times out, and the ack is suppressed. Ack is qualified by req in the completing cycle.
- Only one outstanding access exists at any time. A simultaneous i_req and d_req is resolved at IDLE only. A request that arrives during BUSY waits.
- m_ready seen in IDLE is ignored.

## Timing
- Minimum latency is 2 cycles: req sampled at edge 0, m_req high after edge 0, m_ready in cycle 1, ack high after edge 1.
- Back-to-back accesses take 3 cycles each. The ack cycle is the IDLE arbitration cycle, and the acked requester is ineligible in that cycle.
- rdata registers hold until the next completion for the same requester.
- stall rises combinationally with req and falls in the ack cycle.
- Reset asserted mid-access: all outputs return to their reset values immediately. No ack is issued for the aborted access.

## Configuration
- PIPE_MEM_ARB_RR_EN:
  - Defined: round-robin arbitration. A 1-bit pointer records the last granted requester, and on a simultaneous request the other requester wins.
  - Undefined: fixed data-over-fetch priority, and the pointer is not implemented.

## Test plan
- Single fetch, i_addr=0x40, memory returns 0x8C220004 with m_ready 1 cycle after m_req: m_req high 1 cycle, i_ack pulse 2 cycles after i_req, i_rdata=0x8C220004, stall low in the ack cycle.
- Simultaneous i_req(0x44) and d_req load(0x100), memory latency 3: d served first, d_ack with d_rdata; i_ack follows 4 cycles later. With RR_EN and last grant=data, fetch is served first instead.
- Store d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF: m_we=1, m_addr=0x200, m_wdata=0xDEADBEEF held until m_ready; d_ack one pulse; m_we=0 afterwards.
- m_ready never asserted, TMO=4: m_req drops after 4 BUSY cycles; d_ack and bus_err pulse together; d_rdata=0; next request is granted normally.
- resetn pulled low during DBUSY: m_req, acks and bus_err at 0 immediately. After release, a held d_req is re-granted from IDLE and completes normally.
- d_req dropped during DBUSY, then m_ready: no d_ack, FSM returns to IDLE, a pending i_req is granted next cycle.
